mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of multiplier bits processed per operation.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start_valid  input  1  operand pair present on the datapath inputs.
REQ-005 The block SHALL have port start_ready  output  1  sequencer able to accept an operation.
REQ-006 The block SHALL have port mult_lsb  input  1  current LSB of the datapath's shifted multiplier.
REQ-007 The block SHALL have port mult_zero  input  1  remaining shifted multiplier is all zero.
REQ-008 The block SHALL have port count_check  input  1  datapath counter terminal flag.
REQ-009 The block SHALL have port load_words  output  1  one-cycle operand load strobe to the datapath.
REQ-010 The block SHALL have port add_shift  output  1  accumulate-and-shift strobe.
REQ-011 The block SHALL have port shift  output  1  shift-only strobe.
REQ-012 The block SHALL have port ready  output  1  product valid, held until acknowledged.
REQ-013 The block SHALL have port result_ack  input  1  consumer has taken the product.
REQ-014 The block SHALL have port busy  output  1  operation in progress (any state except IDLE).
REQ-015 The block SHALL have port steps  output  $clog2(WIDTH+1)  step cycles executed by the last operation.
REQ-016 The block SHALL have port err  output  1  sticky counter-mismatch flag.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, LOAD, STEP and DONE.
REQ-018 In IDLE: start_ready=1; start_valid=1 moves the FSM to LOAD at the next edge (acceptance), clears steps and clears err.
REQ-019 In LOAD: load_words=1 for exactly one cycle; the FSM then moves to STEP.
REQ-020 In each STEP cycle exactly one strobe is asserted: add_shift when mult_lsb=1, shift when mult_lsb=0; the internal step counter increments; steps tracks the counter.
REQ-021 STEP SHALL exit to DONE after the WIDTH-th strobe cycle.
REQ-022 Latency: acceptance at edge N, load_words in cycle N+1, strobes in cycles N+2..N+WIDTH+1, ready=1 from cycle N+WIDTH+2.
REQ-023 In DONE: ready=1 and steps stable; result_ack=1 moves the FSM to IDLE at the next edge, and ready drops in that cycle.
REQ-024 start_valid outside IDLE SHALL be ignored; start_ready=0 in LOAD, STEP and DONE, including the DONE cycle that sees result_ack.
REQ-025 result_ack outside DONE SHALL be ignored.
REQ-026 err SHALL be set when count_check=1 in a STEP cycle before the final step, or when count_check=0 in the final step cycle.
REQ-027 err SHALL be sticky until the next acceptance and SHALL NOT alter the FSM sequence.
REQ-028 load_words, add_shift and shift SHALL be mutually exclusive in every cycle.
REQ-029 All outputs SHALL be registered or decoded solely from the state register; there are no combinational input-to-output paths.

Reset
REQ-030 The block SHALL use an asynchronous, active-high reset on reset, with clock clk.
REQ-031 On reset, from any state including mid-STEP: state=IDLE, start_ready=1, busy=0, ready=0, load_words=0, add_shift=0, shift=0, steps=0, err=0.
REQ-032 The first acceptance is possible at the first rising edge after reset deasserts.

Configuration
REQ-033 With macro MULT_SEQ_SKIP_ZERO_EN defined: a STEP cycle that samples mult_zero=1 asserts no strobe, does not increment the step counter, and moves to DONE.
REQ-034 With MULT_SEQ_SKIP_ZERO_EN defined, err checking (REQ-026) SHALL be suppressed for an early-terminated operation.
REQ-035 Without MULT_SEQ_SKIP_ZERO_EN: mult_zero is ignored and every operation runs exactly WIDTH steps.

Verification
REQ-036 WIDTH=16, multiplier 0x0005, count_check on the 16th step -> 2 add_shift and 14 shift pulses; ready 18 cycles after acceptance; steps=16; err=0.
REQ-037 Same operation with count_check asserted on the 10th step -> err=1 in DONE; the next acceptance clears err.
REQ-038 SKIP_ZERO build, multiplier 0x0005, mult_zero high from the 4th step cycle -> add_shift, shift, add_shift, then DONE; steps=3.
REQ-039 reset pulsed during the 7th step -> all strobes drop immediately; busy=0; start_ready=1; steps=0; a new operation completes normally.
REQ-040 ready held with result_ack low for 5 cycles while start_valid=1 -> ready stays 1, no load_words pulse; ack causes IDLE, then acceptance on the following edge.

Source files
------------

// File: rtl/mult_sequencer.sv
// Control sequencer for a shift-and-add multiplier datapath: IDLE/LOAD/STEP/DONE.
// Optional zero-multiplier early exit is built when MULT_SEQ_SKIP_ZERO_EN is defined.
module mult_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic                         mult_lsb,
    input  logic                         mult_zero,
    input  logic                         count_check,
    output logic                         load_words,
    output logic                         add_shift,
    output logic                         shift,
    output logic                         ready,
    input  logic                         result_ack,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   steps,
    output logic                         err
);

    localparam int SW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STEP,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          add_next;
    logic          shift_next;
    logic          err_next;
    logic          mism;
    logic          mism_next;
    logic [SW-1:0] steps_next;
    logic          final_step;
    logic          skip;

`ifdef MULT_SEQ_SKIP_ZERO_EN
    assign skip = mult_zero;
`else
    logic unused_mult_zero;
    assign unused_mult_zero = mult_zero;
    assign skip = 1'b0;
`endif

    assign final_step = (steps == LAST_STEP);

    // Strobes are registered, so mult_lsb/mult_zero are sampled at the edge that
    // opens the strobe cycle they select; count_check is sampled at its closing edge.
    always_comb begin
        state_next = state;
        add_next   = 1'b0;
        shift_next = 1'b0;
        steps_next = steps;
        err_next   = err;
        mism_next  = mism;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    state_next = LOAD;
                    steps_next = '0;
                    err_next   = 1'b0;
                    mism_next  = 1'b0;
                end
            end
            LOAD: begin
                if (skip) begin
                    state_next = DONE;
                end else begin
                    state_next = STEP;
                    add_next   = mult_lsb;
                    shift_next = ~mult_lsb;
                    steps_next = SW'(1);
                end
            end
            STEP: begin
                mism_next = mism | (final_step ? ~count_check : count_check);
                if (final_step) begin
                    state_next = DONE;
                    err_next   = mism_next;
                end else if (skip) begin
                    // early exit leaves err clear: counter checks do not apply
                    state_next = DONE;
                end else begin
                    state_next = STEP;
                    add_next   = mult_lsb;
                    shift_next = ~mult_lsb;
                    steps_next = steps + SW'(1);
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            add_shift <= 1'b0;
            shift     <= 1'b0;
            steps     <= '0;
            err       <= 1'b0;
            mism      <= 1'b0;
        end else begin
            state     <= state_next;
            add_shift <= add_next;
            shift     <= shift_next;
            steps     <= steps_next;
            err       <= err_next;
            mism      <= mism_next;
        end
    end

    assign start_ready = (state == IDLE);
    assign load_words  = (state == LOAD);
    assign ready       = (state == DONE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: directed operations queue their expected
// strobe counts/pattern, steps, err and latency; a monitor checks on ready.
module tb_mult_sequencer;

    localparam int WIDTH = 16;
    localparam int SW    = $clog2(WIDTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic          mult_lsb = 1'b0;
    logic          mult_zero = 1'b0;
    logic          count_check = 1'b0;
    logic          load_words;
    logic          add_shift;
    logic          shift;
    logic          ready;
    logic          result_ack = 1'b0;
    logic          busy;
    logic [SW-1:0] steps;
    logic          err;

    mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mult_lsb    (mult_lsb),
        .mult_zero   (mult_zero),
        .count_check (count_check),
        .load_words  (load_words),
        .add_shift   (add_shift),
        .shift       (shift),
        .ready       (ready),
        .result_ack  (result_ack),
        .busy        (busy),
        .steps       (steps),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] m;
        int          cc;
        int          adds;
        int          shifts;
        int          nsteps;
        logic        err;
    } vec_t;

    vec_t vecs[6];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // monitor / scoreboard
    logic        in_op = 1'b0;
    logic        prev_ready = 1'b0;
    int          cyc, nadd, nshift, nload;
    logic [15:0] pat;
    vec_t        mon_e;

    always @(negedge clk) begin
        if (reset) begin
            in_op      = 1'b0;
            prev_ready = 1'b0;
        end else begin
            check("strobe_exclusive", int'(load_words) + int'(add_shift) + int'(shift) <= 1, 1);
            if (in_op) begin
                cyc++;
                if (load_words) nload++;
                if (add_shift || shift) begin
                    if (nadd + nshift < 16) pat[nadd + nshift] = add_shift;
                    if (add_shift) nadd++;
                    else nshift++;
                end
                if (cyc == 1) begin
                    check("first_cycle_load", load_words, 1);
                    check("first_cycle_err", err, 0);
                    check("first_cycle_steps", steps, 0);
                    check("first_cycle_start_ready", start_ready, 0);
                end
                if (ready && !prev_ready) begin
                    in_op = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("add_shift_count", nadd, mon_e.adds);
                        check("shift_count", nshift, mon_e.shifts);
                        check("strobe_pattern", pat, mon_e.m);
                        check("steps", steps, mon_e.nsteps);
                        check("err", err, mon_e.err);
                        check("load_pulses", nload, 1);
                        check("latency", cyc, (mon_e.nsteps == WIDTH) ? WIDTH + 2 : mon_e.nsteps + 2);
                    end
                end
            end
            if (start_valid && start_ready) begin
                in_op  = 1'b1;
                cyc    = 0;
                nadd   = 0;
                nshift = 0;
                nload  = 0;
                pat    = '0;
            end
            prev_ready = ready;
        end
    end

    // Entered #1 after a rising edge; leaves #1 after the edge that closes the last step.
    task automatic run_op(input vec_t v, output int waited);
        waited = 0;
        start_valid = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!start_ready && waited < 50);
        if (!start_ready) check("accept_timeout", 0, 1);
        exp_q.push_back(v);
        @(posedge clk); #1;
        start_valid = 1'b0;
        mult_lsb    = v.m[0];
        mult_zero   = (v.m == 16'h0);
        count_check = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            count_check = (k == v.cc);
            if (k < 16) begin
                mult_lsb  = v.m[k];
                mult_zero = ((v.m >> k) == 16'h0);
            end else begin
                mult_lsb  = 1'b0;
                mult_zero = 1'b1;
            end
        end
        @(posedge clk); #1;
        count_check = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic ack();
        @(posedge clk); #1;
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
    endtask

    initial begin
        int w;
        // m, count_check step, add_shift, shift, steps, err (hand-computed)
        vecs[0] = '{16'h0005, 16, 2, 14, 16, 1'b0};
        vecs[1] = '{16'h0005, 10, 2, 14, 16, 1'b1};
        vecs[2] = '{16'hFFFF, 16, 16, 0, 16, 1'b0};
        vecs[3] = '{16'h0000, 16, 0, 16, 16, 1'b0};
        vecs[4] = '{16'h8001, 0, 2, 14, 16, 1'b1};
        vecs[5] = '{16'hA5C3, 16, 8, 8, 16, 1'b0};
`ifdef MULT_SEQ_SKIP_ZERO_EN
        vecs[0] = '{16'h0005, 16, 2, 1, 3, 1'b0};
        vecs[1] = '{16'h0005, 10, 2, 1, 3, 1'b0};
        vecs[3] = '{16'h0000, 16, 0, 0, 0, 1'b0};
`endif

        #1 reset = 1'b1;
        #1;
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_strobes", {load_words, add_shift, shift}, 0);
        check("rst_steps", steps, 0);
        check("rst_err", err, 0);

        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], w);
            if (i == 0) check("first_accept_after_reset", w, 1);
            wait_ready();
            ack();
        end

        // ready held without ack while start_valid is high
        run_op(vecs[0], w);
        wait_ready();
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_ready", ready, 1);
            check("hold_no_load", load_words, 0);
            check("hold_start_ready", start_ready, 0);
        end
        @(posedge clk); #1;
        result_ack = 1'b1;
        #1;
        check("ack_cycle_start_ready", start_ready, 0);
        check("ack_cycle_ready", ready, 1);
        @(posedge clk); #1;
        result_ack = 1'b0;
        check("after_ack_ready", ready, 0);
        check("after_ack_start_ready", start_ready, 1);
        run_op(vecs[5], w);
        check("accept_after_ack", w, 1);
        wait_ready();
        ack();

        // reset during the 7th step
        start_valid = 1'b1;
        @(negedge clk);
        check("rst_test_start_ready", start_ready, 1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        mult_lsb    = 1'b1;
        mult_zero   = 1'b0;
        for (int k = 1; k < 7; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("pre_reset_add_shift", add_shift, 1);
        check("pre_reset_steps", steps, 7);
        reset = 1'b1;
        #1;
        check("mid_rst_strobes", {load_words, add_shift, shift}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_start_ready", start_ready, 1);
        check("mid_rst_steps", steps, 0);
        check("mid_rst_ready", ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        mult_lsb = 1'b0;
        run_op(vecs[2], w);
        wait_ready();
        ack();

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
